// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_if
// Purpose : Signal bundle joining the fetch port (A), data port (B) and the
//           single-port memory to mem_arbiter.
// Rev     : 1.0
// ============================================================================
interface mem_arbiter_if;
    logic        i_a_req;
    logic [15:0] i_a_addr;
    logic        o_a_ack;
    logic [31:0] o_a_rdata;
    logic        o_a_err;

    logic        i_b_req;
    logic [15:0] i_b_addr;
    logic [31:0] i_b_wdata;
    logic [1:0]  i_b_size;
    logic        i_b_wr;
    logic        o_b_ack;
    logic [31:0] o_b_rdata;
    logic        o_b_err;

    logic [15:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic [1:0]  o_mem_size;
    logic        o_mem_we;
    logic [31:0] i_mem_rdata;

    // Arbiter side
    modport slave (
        input  i_a_req, i_a_addr,
        output o_a_ack, o_a_rdata, o_a_err,
        input  i_b_req, i_b_addr, i_b_wdata, i_b_size, i_b_wr,
        output o_b_ack, o_b_rdata, o_b_err,
        output o_mem_addr, o_mem_data, o_mem_size, o_mem_we,
        input  i_mem_rdata
    );

    // Requesters and memory side
    modport master (
        output i_a_req, i_a_addr,
        input  o_a_ack, o_a_rdata, o_a_err,
        output i_b_req, i_b_addr, i_b_wdata, i_b_size, i_b_wr,
        input  o_b_ack, o_b_rdata, o_b_err,
        input  o_mem_addr, o_mem_data, o_mem_size, o_mem_we,
        output i_mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Two-port (fetch A / data B) round-robin arbiter in front of a
//           single-port memory, with optional misalignment rejection.
// Rev     : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ALIGN_CHECK = 1
) (
    input  wire logic    i_clk,
    input  wire logic    i_rst_n,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_RSVD = 2'b10;
    localparam logic [1:0] c_SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_gnt_b;
    logic        r_last_b;
    logic        r_wr;
    logic        r_err;
    logic [15:0] r_mem_addr;
    logic [31:0] r_mem_data;
    logic [1:0]  r_mem_size;

    logic        w_load;
    logic        w_pick_b;
    logic        w_pick_err;
    logic        w_a_err;
    logic        w_b_misal;
    logic        w_b_err;
    logic        w_a_resp;
    logic        w_b_resp;

    always_comb begin
        w_b_misal = 1'b0;
        case (bus.i_b_size)
            c_SIZE_BYTE: w_b_misal = 1'b0;
            c_SIZE_HALF: w_b_misal = bus.i_b_addr[0];
            c_SIZE_WORD: w_b_misal = (bus.i_b_addr[1:0] != 2'b00);
            c_SIZE_RSVD: w_b_misal = 1'b1;
            default:     w_b_misal = 1'b1;
        endcase
    end

    assign w_a_err    = (ALIGN_CHECK != 0) && (bus.i_a_addr[1:0] != 2'b00);
    assign w_b_err    = (ALIGN_CHECK != 0) && w_b_misal;
    assign w_pick_err = w_pick_b ? w_b_err : w_a_err;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pick_b    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_a_req && bus.i_b_req) begin
                    w_load   = 1'b1;
                    w_pick_b = ~r_last_b;
                end else if (bus.i_a_req) begin
                    w_load   = 1'b1;
                end else if (bus.i_b_req) begin
                    w_load   = 1'b1;
                    w_pick_b = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // The served port still holds req this cycle, so only the other one competes
                if (r_gnt_b ? bus.i_a_req : bus.i_b_req) begin
                    w_load   = 1'b1;
                    w_pick_b = ~r_gnt_b;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_load) begin
            w_state_nxt = ST_ISSUE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_gnt_b  <= 1'b0;
            r_last_b <= 1'b1;
            r_wr     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_RESP) begin
                r_last_b <= r_gnt_b;
            end
            if (w_load) begin
                r_gnt_b <= w_pick_b;
                r_wr    <= w_pick_b & bus.i_b_wr;
                r_err   <= w_pick_err;
            end
        end
    end

    // Rejected accesses leave the memory bus untouched
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_addr <= 16'h0000;
            r_mem_data <= 32'h0000_0000;
            r_mem_size <= c_SIZE_WORD;
        end else if (w_load && !w_pick_err) begin
            if (w_pick_b) begin
                r_mem_addr <= bus.i_b_addr;
                r_mem_data <= bus.i_b_wdata;
                r_mem_size <= bus.i_b_size;
            end else begin
                r_mem_addr <= bus.i_a_addr;
                r_mem_size <= c_SIZE_WORD;
            end
        end
    end

    assign w_a_resp = (r_state == ST_RESP) && !r_gnt_b;
    assign w_b_resp = (r_state == ST_RESP) &&  r_gnt_b;

    assign bus.o_mem_addr = r_mem_addr;
    assign bus.o_mem_data = r_mem_data;
    assign bus.o_mem_size = r_mem_size;
    assign bus.o_mem_we   = !((r_state == ST_ISSUE) && r_wr && !r_err);

    assign bus.o_a_ack   = w_a_resp;
    assign bus.o_a_err   = w_a_resp && r_err;
    assign bus.o_a_rdata = (w_a_resp && !r_err) ? bus.i_mem_rdata : 32'h0000_0000;

    assign bus.o_b_ack   = w_b_resp;
    assign bus.o_b_err   = w_b_resp && r_err;
    assign bus.o_b_rdata = (w_b_resp && !r_err && !r_wr) ? bus.i_mem_rdata : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Vector table plus scoreboard bench for mem_arbiter, covering the
//           strict-alignment and pass-through builds.
// Rev     : 1.0
// ============================================================================
module tb_mem_arbiter;
    logic clk;
    logic rst_n;

    mem_arbiter_if bus();
    mem_arbiter_if bus_nc();

    mem_arbiter #(.ALIGN_CHECK(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    mem_arbiter #(.ALIGN_CHECK(0)) dut_nc (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_nc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        port_b;
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_we_low;
    } vec_t;

    logic [7:0] mem    [0:65535];
    logic [7:0] mem_nc [0:65535];

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t e_mon;
    vec_t vecs[18];

    int n_vec = 0;
    int n_err = 0;
    int we_low_cnt = 0;
    int we_low_nc = 0;
    int ack_a_cnt = 0;
    int ack_b_cnt = 0;
    logic mon_en = 1'b0;

    int ta, tb_, ka, kb, rep, last, first_port, cyc_last, we0, a0, n;
    logic got;

    function automatic int f_nbytes(input logic [1:0] size);
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Byte-addressed memories: sample/write at each rising edge, read data valid next cycle
    always @(posedge clk) begin : p_mem
        logic [31:0] rd;
        rd = 32'h0;
        for (int k = 0; k < f_nbytes(bus.o_mem_size); k++) begin
            rd[8*k +: 8] = mem[bus.o_mem_addr + 16'(k)];
            if (!bus.o_mem_we) mem[bus.o_mem_addr + 16'(k)] = bus.o_mem_data[8*k +: 8];
        end
        bus.i_mem_rdata <= rd;
    end

    always @(posedge clk) begin : p_mem_nc
        logic [31:0] rd;
        rd = 32'h0;
        for (int k = 0; k < f_nbytes(bus_nc.o_mem_size); k++) begin
            rd[8*k +: 8] = mem_nc[bus_nc.o_mem_addr + 16'(k)];
            if (!bus_nc.o_mem_we) mem_nc[bus_nc.o_mem_addr + 16'(k)] = bus_nc.o_mem_data[8*k +: 8];
        end
        bus_nc.i_mem_rdata <= rd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard: every ack pops the oldest expectation for that port
    always @(negedge clk) begin
        if (!bus.o_mem_we)    we_low_cnt++;
        if (!bus_nc.o_mem_we) we_low_nc++;
        if (mon_en) begin
            check("dual_ack", 32'(bus.o_a_ack & bus.o_b_ack), 32'h0);
            if (bus.o_a_ack) begin
                ack_a_cnt++;
                if (exp_a.size() == 0) check("a_unexpected_ack", 32'h1, 32'h0);
                else begin
                    e_mon = exp_a.pop_front();
                    check("a_rdata", bus.o_a_rdata, e_mon.rdata);
                    check("a_err", 32'(bus.o_a_err), 32'(e_mon.err));
                end
            end else begin
                check("a_idle_rdata_err", bus.o_a_rdata | 32'(bus.o_a_err), 32'h0);
            end
            if (bus.o_b_ack) begin
                ack_b_cnt++;
                if (exp_b.size() == 0) check("b_unexpected_ack", 32'h1, 32'h0);
                else begin
                    e_mon = exp_b.pop_front();
                    check("b_rdata", bus.o_b_rdata, e_mon.rdata);
                    check("b_err", 32'(bus.o_b_err), 32'(e_mon.err));
                end
            end else begin
                check("b_idle_rdata_err", bus.o_b_rdata | 32'(bus.o_b_err), 32'h0);
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_mem_we"},   32'(bus.o_mem_we), 32'h1);
        check({tag, "_mem_addr"}, 32'(bus.o_mem_addr), 32'h0);
        check({tag, "_mem_data"}, bus.o_mem_data, 32'h0);
        check({tag, "_mem_size"}, 32'(bus.o_mem_size), 32'h3);
        check({tag, "_acks_errs"}, 32'({bus.o_a_ack, bus.o_b_ack, bus.o_a_err, bus.o_b_err}), 32'h0);
        check({tag, "_rdata"}, bus.o_a_rdata | bus.o_b_rdata, 32'h0);
    endtask

    task automatic do_access(input vec_t v);
        int cnt;
        int w0;
        logic seen;
        @(negedge clk);
        w0 = we_low_cnt;
        if (v.port_b) begin
            exp_b.push_back('{v.exp_rdata, v.exp_err});
            bus.i_b_req   = 1'b1;
            bus.i_b_wr    = v.wr;
            bus.i_b_addr  = v.addr;
            bus.i_b_size  = v.size;
            bus.i_b_wdata = v.wdata;
        end else begin
            exp_a.push_back('{v.exp_rdata, v.exp_err});
            bus.i_a_req  = 1'b1;
            bus.i_a_addr = v.addr;
        end
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 10) begin
            @(negedge clk);
            cnt++;
            seen = v.port_b ? bus.o_b_ack : bus.o_a_ack;
        end
        check("ack_latency", 32'(cnt), 32'd2);
        @(posedge clk);
        #1;
        bus.i_a_req = 1'b0;
        bus.i_b_req = 1'b0;
        check("mem_we_low_cycles", 32'(we_low_cnt - w0), 32'(v.exp_we_low));
    endtask

    task automatic nc_access(input logic wr, input logic [15:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata, input int exp_we);
        int cnt;
        int w0;
        logic seen;
        @(negedge clk);
        w0 = we_low_nc;
        bus_nc.i_b_req   = 1'b1;
        bus_nc.i_b_wr    = wr;
        bus_nc.i_b_addr  = addr;
        bus_nc.i_b_size  = size;
        bus_nc.i_b_wdata = wdata;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 10) begin
            @(negedge clk);
            cnt++;
            seen = bus_nc.o_b_ack;
        end
        check("nc_ack_latency", 32'(cnt), 32'd2);
        check("nc_err", 32'(bus_nc.o_b_err), 32'h0);
        check("nc_rdata", bus_nc.o_b_rdata, exp_rdata);
        @(posedge clk);
        #1;
        bus_nc.i_b_req = 1'b0;
        check("nc_we_low_cycles", 32'(we_low_nc - w0), 32'(exp_we));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_a_req = 1'b0;    bus.i_a_addr = 16'h0;
        bus.i_b_req = 1'b0;    bus.i_b_addr = 16'h0;   bus.i_b_wdata = 32'h0;
        bus.i_b_size = 2'b11;  bus.i_b_wr = 1'b0;
        bus_nc.i_a_req = 1'b0; bus_nc.i_a_addr = 16'h0;
        bus_nc.i_b_req = 1'b0; bus_nc.i_b_addr = 16'h0; bus_nc.i_b_wdata = 32'h0;
        bus_nc.i_b_size = 2'b11; bus_nc.i_b_wr = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 8'h00;
            mem_nc[i] = i[7:0];
        end

        //          B     wr    addr     size   wdata          exp_rdata      err   we
        vecs[0]  = '{1'b1, 1'b1, 16'h0004, 2'b11, 32'hDEADBEEF, 32'h00000000, 1'b0, 1};
        vecs[1]  = '{1'b0, 1'b0, 16'h0004, 2'b11, 32'h00000000, 32'hDEADBEEF, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b1, 16'h0007, 2'b00, 32'h00000055, 32'h00000000, 1'b0, 1};
        vecs[3]  = '{1'b1, 1'b0, 16'h0007, 2'b00, 32'h00000000, 32'h00000055, 1'b0, 0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0004, 2'b11, 32'h00000000, 32'h55ADBEEF, 1'b0, 0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0005, 2'b00, 32'h00000000, 32'h000000BE, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b1, 16'h0008, 2'b01, 32'h00001234, 32'h00000000, 1'b0, 1};
        vecs[7]  = '{1'b1, 1'b0, 16'h0008, 2'b01, 32'h00000000, 32'h00001234, 1'b0, 0};
        vecs[8]  = '{1'b1, 1'b0, 16'h0003, 2'b01, 32'h00000000, 32'h00000000, 1'b1, 0};
        vecs[9]  = '{1'b1, 1'b0, 16'h0006, 2'b11, 32'h00000000, 32'h00000000, 1'b1, 0};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 2'b10, 32'h00000000, 32'h00000000, 1'b1, 0};
        vecs[11] = '{1'b0, 1'b0, 16'h0002, 2'b11, 32'h00000000, 32'h00000000, 1'b1, 0};
        vecs[12] = '{1'b1, 1'b1, 16'h0000, 2'b11, 32'hCAFEF00D, 32'h00000000, 1'b0, 1};
        vecs[13] = '{1'b1, 1'b1, 16'h0001, 2'b11, 32'h11111111, 32'h00000000, 1'b1, 0};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 2'b11, 32'h00000000, 32'hCAFEF00D, 1'b0, 0};
        vecs[15] = '{1'b1, 1'b0, 16'h0009, 2'b00, 32'h00000000, 32'h00000012, 1'b0, 0};
        vecs[16] = '{1'b1, 1'b1, 16'h000A, 2'b00, 32'hFFFFFF77, 32'h00000000, 1'b0, 1};
        vecs[17] = '{1'b1, 1'b0, 16'h0008, 2'b11, 32'h00000000, 32'h00771234, 1'b0, 0};

        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("idle_after_release");
        mon_en = 1'b1;

        for (int i = 0; i < 18; i++) do_access(vecs[i]);

        // Simultaneous requests straight after reset: A first, B two cycles later
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        exp_a.push_back('{32'hCAFEF00D, 1'b0});
        exp_b.push_back('{32'h0000CAFE, 1'b0});
        bus.i_a_req = 1'b1; bus.i_a_addr = 16'h0000;
        bus.i_b_req = 1'b1; bus.i_b_addr = 16'h0002; bus.i_b_size = 2'b01; bus.i_b_wr = 1'b0;
        ta = -1; tb_ = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.o_a_ack && ta < 0)  ta  = c;
            if (bus.o_b_ack && tb_ < 0) tb_ = c;
            @(posedge clk);
            #1;
            if (ta >= 0)  bus.i_a_req = 1'b0;
            if (tb_ >= 0) bus.i_b_req = 1'b0;
        end
        check("contention_a_ack_cycle", 32'(ta), 32'd2);
        check("contention_b_ack_cycle", 32'(tb_), 32'd4);

        // Both ports streaming: four accesses each, strictly alternating
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_a.push_back('{32'h55ADBEEF, 1'b0});
            exp_b.push_back('{32'h00771234, 1'b0});
        end
        bus.i_a_req = 1'b1; bus.i_a_addr = 16'h0004;
        bus.i_b_req = 1'b1; bus.i_b_addr = 16'h0008; bus.i_b_size = 2'b11; bus.i_b_wr = 1'b0;
        ka = 0; kb = 0; rep = 0; last = -1; first_port = -1; cyc_last = -1;
        for (int c = 1; c <= 40 && (ka < 4 || kb < 4); c++) begin
            @(negedge clk);
            if (bus.o_a_ack) begin
                if (last == 0) rep++;
                if (first_port < 0) first_port = 0;
                last = 0; ka++; cyc_last = c;
            end
            if (bus.o_b_ack) begin
                if (last == 1) rep++;
                if (first_port < 0) first_port = 1;
                last = 1; kb++; cyc_last = c;
            end
            @(posedge clk);
            #1;
            if (ka >= 4) bus.i_a_req = 1'b0;
            if (kb >= 4) bus.i_b_req = 1'b0;
        end
        check("stream_a_acks", 32'(ka), 32'd4);
        check("stream_b_acks", 32'(kb), 32'd4);
        check("stream_repeats", 32'(rep), 32'd0);
        check("stream_first_port", 32'(first_port), 32'd0);
        check("stream_last_ack_cycle", 32'(cyc_last), 32'd16);

        // Reset lands mid-ISSUE of a byte write: write dropped, outputs cleared at once
        @(negedge clk);
        bus.i_b_req = 1'b1; bus.i_b_wr = 1'b1; bus.i_b_addr = 16'h0007;
        bus.i_b_size = 2'b00; bus.i_b_wdata = 32'h000000AB;
        @(posedge clk);
        #2;
        check("abort_write_in_flight", 32'(bus.o_mem_we), 32'h0);
        rst_n = 1'b0;
        #1;
        check_reset("async_reset_mid_issue");
        we0 = we_low_cnt;
        @(negedge clk);
        bus.i_b_req = 1'b0;
        @(negedge clk);
        exp_b.push_back('{32'h00000055, 1'b0});
        bus.i_b_req = 1'b1; bus.i_b_wr = 1'b0; bus.i_b_addr = 16'h0007; bus.i_b_size = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            got = bus.o_b_ack;
        end
        check("first_grant_after_release", 32'(n), 32'd2);
        @(posedge clk);
        #1;
        bus.i_b_req = 1'b0;
        check("aborted_write_we_low", 32'(we_low_cnt - we0), 32'd0);

        // Lone requester holding req through its ack gets exactly one access
        a0 = ack_a_cnt;
        do_access('{1'b0, 1'b0, 16'h0008, 2'b11, 32'h0, 32'h00771234, 1'b0, 0});
        repeat (6) @(negedge clk);
        check("single_req_one_ack", 32'(ack_a_cnt - a0), 32'd1);

        // Pass-through build: misaligned and reserved-size accesses reach memory
        nc_access(1'b0, 16'h0003, 2'b01, 32'h0,         32'h00000403, 0);
        nc_access(1'b0, 16'h0006, 2'b11, 32'h0,         32'h09080706, 0);
        nc_access(1'b0, 16'h0000, 2'b10, 32'h0,         32'h03020100, 0);
        nc_access(1'b1, 16'h0001, 2'b11, 32'hA1B2C3D4, 32'h00000000, 1);
        nc_access(1'b0, 16'h0001, 2'b11, 32'h0,         32'hA1B2C3D4, 0);
        nc_access(1'b0, 16'h0004, 2'b00, 32'h0,         32'h000000A1, 0);

        repeat (2) @(negedge clk);
        check("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
